// File: rtl/seg7_scan_ctrl.sv
// Two-digit multiplexed 7-segment driver: high nibble on digit 1, low nibble on digit 2,
// with a dark gap between digit slots and a one-deep pending register behind valid/ready.
module seg7_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500,
  parameter int LZ_BLANK  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din_valid,
  input  logic [7:0] din,
  output logic       din_ready,
  output logic       sm_cs1_n,
  output logic       sm_cs2_n,
  output logic [6:0] sm_db
);

  localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {S_BLK_LO, S_HI, S_BLK_HI, S_LO} state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   timer, timer_nx, lim;
  logic            tdone, commit;
  logic [7:0]      disp_r, disp_nx, pend_val;
  logic            pend_r;
  logic            cs1_nx, cs2_nx;
  logic [6:0]      db_nx;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'h3f;  4'h1: seg = 7'h06;  4'h2: seg = 7'h5b;  4'h3: seg = 7'h4f;
      4'h4: seg = 7'h66;  4'h5: seg = 7'h6d;  4'h6: seg = 7'h7d;  4'h7: seg = 7'h07;
      4'h8: seg = 7'h7f;  4'h9: seg = 7'h6f;  4'ha: seg = 7'h77;  4'hb: seg = 7'h7c;
      4'hc: seg = 7'h39;  4'hd: seg = 7'h5e;  4'he: seg = 7'h79;  default: seg = 7'h71;
    endcase
  endfunction

  assign din_ready = ~pend_r;

  always_comb begin
    lim      = (state == S_HI || state == S_LO) ? TW'(SCAN_DIV - 1) : TW'(BLANK_CYC - 1);
    tdone    = (timer == lim);
    state_nx = state;
    timer_nx = timer + TW'(1);
    if (tdone) begin
      timer_nx = '0;
      case (state)
        S_BLK_LO: state_nx = S_HI;
        S_HI:     state_nx = S_BLK_HI;
        S_BLK_HI: state_nx = S_LO;
        default:  state_nx = S_BLK_LO;
      endcase
    end
    // New values only land at frame start so a frame never mixes two values.
    commit  = tdone && (state == S_BLK_LO) && pend_r;
    disp_nx = commit ? pend_val : disp_r;

    // Outputs are decoded from the next state so they switch with it.
    cs1_nx = 1'b1;
    cs2_nx = 1'b1;
    db_nx  = '0;
    case (state_nx)
      S_HI: begin
        cs1_nx = (LZ_BLANK != 0) && (disp_nx[7:4] == 4'h0);
        db_nx  = seg(disp_nx[7:4]);
      end
      S_LO: begin
        cs2_nx = 1'b0;
        db_nx  = seg(disp_nx[3:0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_BLK_LO;
      timer    <= '0;
      disp_r   <= 8'h00;
      pend_val <= 8'h00;
      pend_r   <= 1'b0;
      sm_cs1_n <= 1'b1;
      sm_cs2_n <= 1'b1;
      sm_db    <= 7'h00;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      disp_r   <= disp_nx;
      sm_cs1_n <= cs1_nx;
      sm_cs2_n <= cs2_nx;
      sm_db    <= db_nx;
      if (din_valid && !pend_r) begin
        pend_val <= din;
        pend_r   <= 1'b1;
      end else if (commit) begin
        pend_r   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: two instances (leading-zero blanking off/on) share stimulus;
// a frame-phase monitor checks every cycle against values popped from an acceptance queue.
module tb_seg7_scan_ctrl;

  logic       clk = 1'b0, rst_n = 1'b0, din_valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic       rdy0, cs1_0, cs2_0, rdy1, cs1_1, cs2_1;
  logic [6:0] db0, db1;
  logic [6:0] exp_shi = 7'h3f, exp_slo = 7'h3f;

  typedef struct {
    logic [7:0] val;
    logic [6:0] shi;
    logic [6:0] slo;
    int         edge_n;
  } ent_t;

  typedef struct {
    logic [7:0] din;
    logic [6:0] shi;
    logic [6:0] slo;
    int         phase;
  } vec_t;

  ent_t       q[$];
  logic [7:0] disp_v;
  logic [6:0] disp_shi, disp_slo;
  int         cyc;
  int         n_vec = 0, n_err = 0;
  logic [6:0] seg_tab [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                               7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};
  vec_t       vecs [8];

  seg7_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2), .LZ_BLANK(0)) dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .din_ready(rdy0),
    .sm_cs1_n(cs1_0), .sm_cs2_n(cs2_0), .sm_db(db0));

  seg7_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2), .LZ_BLANK(1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .din_ready(rdy1),
    .sm_cs1_n(cs1_1), .sm_cs2_n(cs2_1), .sm_db(db1));

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err < 40) $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Phase within a 20-cycle frame: 0-1 dark, 2-9 digit 1, 10-11 dark, 12-19 digit 2.
  always @(negedge clk) begin
    int         p;
    logic       rdy_e;
    logic [9:0] e0, e1;
    ent_t       ent;
    if (!rst_n) begin
      q.delete();
      disp_v   = 8'h00;
      disp_shi = 7'h3f;
      disp_slo = 7'h3f;
      chk("rst_dark",    {cs1_0, cs2_0, db0, rdy0}, 10'b11_0000000_1);
      chk("rst_dark_lz", {cs1_1, cs2_1, db1, rdy1}, 10'b11_0000000_1);
    end else begin
      p = cyc % 20;
      if (p == 2 && q.size() > 0 && q[0].edge_n < cyc) begin
        ent      = q.pop_front();
        disp_v   = ent.val;
        disp_shi = ent.shi;
        disp_slo = ent.slo;
      end
      rdy_e = (q.size() == 0);
      e0 = {1'b1, 1'b1, 7'h00, rdy_e};
      e1 = e0;
      if (p >= 2 && p <= 9) begin
        e0 = {1'b0, 1'b1, disp_shi, rdy_e};
        e1 = {disp_v[7:4] == 4'h0, 1'b1, disp_shi, rdy_e};
      end else if (p >= 12) begin
        e0 = {1'b1, 1'b0, disp_slo, rdy_e};
        e1 = e0;
      end
      chk("scan",    {cs1_0, cs2_0, db0, rdy0}, e0);
      chk("scan_lz", {cs1_1, cs2_1, db1, rdy1}, e1);
      if (din_valid && rdy_e) q.push_back('{din, exp_shi, exp_slo, cyc + 1});
    end
  end

  task automatic wait_phase(input int p);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (cyc % 20 == p) return;
    end
    chk("phase_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] v, input logic [6:0] sh, input logic [6:0] sl);
    logic acc;
    acc = 1'b0;
    din = v; exp_shi = sh; exp_slo = sl; din_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk); acc = rdy0;
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  initial begin
    logic       take;
    logic [7:0] v;
    vecs[0] = '{8'ha5, 7'h77, 7'h6d, 15};
    vecs[1] = '{8'h12, 7'h06, 7'h5b, -1};
    vecs[2] = '{8'h34, 7'h4f, 7'h66, -1};
    vecs[3] = '{8'h07, 7'h3f, 7'h07, 5};
    vecs[4] = '{8'h00, 7'h3f, 7'h3f, -1};
    vecs[5] = '{8'hff, 7'h71, 7'h71, 13};
    vecs[6] = '{8'h80, 7'h7f, 7'h3f, -1};
    vecs[7] = '{8'hcb, 7'h39, 7'h7c, 0};

    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (45) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      if (vecs[i].phase >= 0) wait_phase(vecs[i].phase);
      send(vecs[i].din, vecs[i].shi, vecs[i].slo);
    end
    repeat (45) @(posedge clk);
    #1;

    // Reset mid digit-2 slot with a value pending: dark at once, pending value lost.
    wait_phase(13);
    send(8'h9c, 7'h6f, 7'h39);
    wait_phase(17);
    #2 rst_n = 1'b0;
    #1;
    chk("async_dark",    {cs1_0, cs2_0, db0}, 9'b11_0000000);
    chk("async_dark_lz", {cs1_1, cs2_1, db1}, 9'b11_0000000);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (45) @(posedge clk);
    #1;

    for (int i = 0; i < 20000; i++) begin
      @(negedge clk); take = din_valid && rdy0;
      @(posedge clk); #1;
      if (!din_valid || take) begin
        if ($urandom_range(3) == 0) begin
          v = 8'($urandom);
          din = v; exp_shi = seg_tab[v[7:4]]; exp_slo = seg_tab[v[3:0]];
          din_valid = 1'b1;
        end else begin
          din_valid = 1'b0;
        end
      end
    end
    din_valid = 1'b0;
    repeat (45) @(posedge clk);
    #1;
    chk("drain", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
